// File: rtl/err_mon_pkg.sv
// Shared types and helpers for the error-event monitor: FSM state encoding
// and a width-generic saturating increment.
package err_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    HELD  = 2'd2,
    CLEAR = 2'd3
  } mon_state_e;

  // Widths must stay below 32 so the all-ones ceiling fits the 32-bit carrier.
  localparam int unsigned SAT_MAX_W = 31;

  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (32'd1 << width) - 32'd1;
    return (value >= maxVal) ? maxVal : value + 32'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; clr_i forces the history bit low so a
// level still high on the following cycle is reported as a fresh edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  input  logic clr_i,
  output logic rise_o
);

  logic sigPrev_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      sigPrev_q <= 1'b0;
    end else begin
      sigPrev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sigPrev_q;

endmodule

// File: rtl/err_event_monitor.sv
// Sticky error-event monitor: counts error events, tracks the longest error
// run and drives a host interrupt with an acknowledge and clear handshake.
module err_event_monitor
  import err_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err_in,
  input  logic             irq_ack,
  input  logic             clr_req,
  output logic             irq,
  output logic             sticky,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [RUN_W-1:0] max_run,
  output logic             clr_done
);

  mon_state_e       state_q;
  logic             irq_q;
  logic             sticky_q;
  logic             clrDone_q;
  logic             clrBlock_q;
  logic [CNT_W-1:0] evtCnt_q;
  logic [CNT_W-1:0] evtCnt_d;
  logic [RUN_W-1:0] runCnt_q;
  logic [RUN_W-1:0] runCnt_d;
  logic [RUN_W-1:0] maxRun_q;
  logic [RUN_W-1:0] maxRun_d;
  logic             rise;
  logic             clrStart;

  // A held clr_req stays blocked after its clear until the host drops it.
  assign clrStart = clr_req & ~clrBlock_q;

  rise_detect u_rise_detect (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (err_in),
    .clr_i  (clrStart),
    .rise_o (rise)
  );

  always_comb begin
    runCnt_d = '0;
    if (err_in) begin
      runCnt_d = RUN_W'(satInc(32'(runCnt_q), RUN_W));
    end
    maxRun_d = (runCnt_d > maxRun_q) ? runCnt_d : maxRun_q;
    evtCnt_d = evtCnt_q;
    if (rise) begin
      evtCnt_d = CNT_W'(satInc(32'(evtCnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clrStart) begin
      evtCnt_q <= '0;
      runCnt_q <= '0;
      maxRun_q <= '0;
    end else begin
      evtCnt_q <= evtCnt_d;
      runCnt_q <= runCnt_d;
      maxRun_q <= maxRun_d;
    end
  end

  // Outputs are written alongside each transition so they reflect the
  // state being entered; a rise re-arms the interrupt from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      sticky_q   <= 1'b0;
      clrDone_q  <= 1'b0;
      clrBlock_q <= 1'b0;
    end else begin
      if (!clr_req) begin
        clrBlock_q <= 1'b0;
      end
      if (clrStart) begin
        state_q    <= CLEAR;
        irq_q      <= 1'b0;
        sticky_q   <= 1'b0;
        clrDone_q  <= 1'b1;
        clrBlock_q <= 1'b1;
      end else begin
        clrDone_q <= 1'b0;
        if (rise) begin
          state_q  <= ALERT;
          irq_q    <= 1'b1;
          sticky_q <= 1'b1;
        end else begin
          case (state_q)
            ALERT: begin
              if (irq_ack) begin
                state_q <= HELD;
                irq_q   <= 1'b0;
              end
            end
            CLEAR: begin
              state_q <= IDLE;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign irq      = irq_q;
  assign sticky   = sticky_q;
  assign evt_cnt  = evtCnt_q;
  assign max_run  = maxRun_q;
  assign clr_done = clrDone_q;

endmodule

// File: tb/tb_err_event_monitor.sv
// Directed bench for err_event_monitor: a default-width instance plus a
// narrow instance (CNT_W=4, RUN_W=3) for saturation, sharing all inputs.
module tb_err_event_monitor;

  logic        clk;
  logic        reset;
  logic        errIn;
  logic        irqAck;
  logic        clrReq;
  logic        irq;
  logic        sticky;
  logic [15:0] evtCnt;
  logic [7:0]  maxRun;
  logic        clrDone;
  logic        irqS;
  logic        stickyS;
  logic [3:0]  evtCntS;
  logic [2:0]  maxRunS;
  logic        clrDoneS;

  int testCount = 0;
  int failCount = 0;

  err_event_monitor #(.CNT_W(16), .RUN_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .err_in   (errIn),
    .irq_ack  (irqAck),
    .clr_req  (clrReq),
    .irq      (irq),
    .sticky   (sticky),
    .evt_cnt  (evtCnt),
    .max_run  (maxRun),
    .clr_done (clrDone)
  );

  err_event_monitor #(.CNT_W(4), .RUN_W(3)) dutSmall (
    .clk      (clk),
    .reset    (reset),
    .err_in   (errIn),
    .irq_ack  (irqAck),
    .clr_req  (clrReq),
    .irq      (irqS),
    .sticky   (stickyS),
    .evt_cnt  (evtCntS),
    .max_run  (maxRunS),
    .clr_done (clrDoneS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic applyStimulus(input logic e, input logic a, input logic c);
    errIn  = e;
    irqAck = a;
    clrReq = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkMain(input string tag, input logic eIrq, input logic eSticky,
                           input logic [15:0] eEvt, input logic [7:0] eMax,
                           input logic eDone);
    checkOutput({tag, ".irq"},      32'(irq),     32'(eIrq));
    checkOutput({tag, ".sticky"},   32'(sticky),  32'(eSticky));
    checkOutput({tag, ".evt_cnt"},  32'(evtCnt),  32'(eEvt));
    checkOutput({tag, ".max_run"},  32'(maxRun),  32'(eMax));
    checkOutput({tag, ".clr_done"}, 32'(clrDone), 32'(eDone));
  endtask

  initial begin
    reset  = 1'b1;
    errIn  = 1'b0;
    irqAck = 1'b0;
    clrReq = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkMain("reset", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    checkOutput("resetSmall.evt_cnt", 32'(evtCntS), 32'd0);
    reset = 1'b0;

    // err_in pattern 0,1,1,0,1,0
    applyStimulus(1'b0, 1'b0, 1'b0); checkMain("p0", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("p1", 1'b1, 1'b1, 16'd1, 8'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("p2", 1'b1, 1'b1, 16'd1, 8'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkMain("p3", 1'b1, 1'b1, 16'd1, 8'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("p4", 1'b1, 1'b1, 16'd2, 8'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkMain("p5", 1'b1, 1'b1, 16'd2, 8'd2, 1'b0);

    // acknowledge, ignored acknowledge, re-arm
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("alertErr", 1'b1, 1'b1, 16'd3, 8'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkMain("ack",      1'b0, 1'b1, 16'd3, 8'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0); checkMain("ackHeld",  1'b0, 1'b1, 16'd3, 8'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("rearm",    1'b1, 1'b1, 16'd4, 8'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0); checkMain("ack2",     1'b0, 1'b1, 16'd4, 8'd2, 1'b0);

    // clr_req held 5 cycles with err_in high
    applyStimulus(1'b1, 1'b0, 1'b1); checkMain("clrEnter", 1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1); checkMain("clrNext",  1'b1, 1'b1, 16'd1, 8'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1); checkMain("clrHold3", 1'b1, 1'b1, 16'd1, 8'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1); checkMain("clrHold5", 1'b1, 1'b1, 16'd1, 8'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("clrDrop",  1'b1, 1'b1, 16'd1, 8'd5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1); checkMain("clrAgain", 1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0); checkMain("clrIdle",  1'b0, 1'b0, 16'd0, 8'd0, 1'b0);

    // clr_req, rise and irq_ack together
    applyStimulus(1'b1, 1'b0, 1'b0); checkMain("sAlert", 1'b1, 1'b1, 16'd1, 8'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1); checkMain("sAll",   1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0); checkMain("sAfter", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);

    // reset during a clear, and reset together with a fresh clear request
    applyStimulus(1'b0, 1'b0, 1'b1); checkMain("rcEnter", 1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1); checkMain("rcReset", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1); checkMain("rcReqReset", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // reset while in ALERT with evt_cnt=9
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkMain("nine", 1'b1, 1'b1, 16'd9, 8'd1, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1); checkMain("alertReset", 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // saturation on the narrow instance
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 14) checkOutput("small15.evt_cnt", 32'(evtCntS), 32'd15);
    end
    checkOutput("pulses20.evt_cnt",      32'(evtCnt),  32'd20);
    checkOutput("smallSat.evt_cnt",      32'(evtCntS), 32'd15);
    checkOutput("smallSat.irq",          32'(irqS),    32'd1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("burst12.max_run",       32'(maxRun),  32'd12);
    checkOutput("burst12.evt_cnt",       32'(evtCnt),  32'd21);
    checkOutput("smallBurst.max_run",    32'(maxRunS), 32'd7);
    checkOutput("smallBurst.evt_cnt",    32'(evtCntS), 32'd15);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
